// File: rtl/rf_wb_pkg.sv
// Shared constants and entry type for the register-file writeback controller.
package rf_wb_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NREGS  = 2 ** RF_ADDR_W;

  // One queued register-file write: destination index and value.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: circular buffer with two push ports and one pop port.
// Push port 0 is the older of two simultaneous pushes; a lone push on port 1
// takes the next free slot. All entries are exported oldest-first together
// with their valid bits so the parent can build scoreboard and bypass views.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push0,
  input  wb_entry_t                i_push0_entry,
  input  logic                     i_push1,
  input  wb_entry_t                i_push1_entry,
  input  logic                     i_pop,
  output wb_entry_t                o_entries [DEPTH],
  output logic [DEPTH-1:0]         o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW:0]     r_count;

  logic [1:0]      w_npush;
  logic            w_pop;
  logic [PW+1:0]   w_occ_next;

  assign w_npush    = {1'b0, i_push0} + {1'b0, i_push1};
  assign w_pop      = i_pop && (r_count != '0);
  assign w_occ_next = {1'b0, r_count} + (PW+2)'(w_npush) - (PW+2)'(w_pop);

  // Storage, pointers and occupancy; entries are cleared on reset so the
  // write-port data reads zero until the first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push0) begin
        r_mem[r_wr_ptr] <= i_push0_entry;
      end
      if (i_push1) begin
        r_mem[i_push0 ? r_wr_ptr + PW'(1) : r_wr_ptr] <= i_push1_entry;
      end
      r_wr_ptr <= r_wr_ptr + PW'(w_npush);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= w_occ_next[PW:0];
    end
  end

  // The parent's ready logic must never let occupancy exceed the buffer.
  assert property (@(posedge clk) disable iff (reset) (w_occ_next <= (PW+2)'(DEPTH)));

  // Present entries oldest-first: slot gi is gi positions behind the head.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
    assign o_entries[gi] = r_mem[r_rd_ptr + PW'(gi)];
    assign o_valid[gi]   = ((PW+1)'(gi) < r_count);
  end

  assign o_count = r_count;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: write-side front end for the 8x16 register file.
// Queues ALU and load writebacks in order, retires one per cycle onto the
// register-file write port, and exports a pending-write mask for hazard checks.
// Build option: define RF_WB_BYPASS_EN to enable the youngest-entry read
// bypass lookups; otherwise byp_* are tied to zero and chk_rr* are ignored.
module rf_writeback_ctrl
  import rf_wb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_wr,
  output logic [DATA_W-1:0]        rf_wd,
  output logic [2**ADDR_W-1:0]     pend_mask,
  output logic [$clog2(DEPTH):0]   q_count,
  input  logic [ADDR_W-1:0]        chk_rr1,
  input  logic [ADDR_W-1:0]        chk_rr2,
  output logic                     byp_hit1,
  output logic [DATA_W-1:0]        byp_data1,
  output logic                     byp_hit2,
  output logic [DATA_W-1:0]        byp_data2
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t       w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  wb_entry_t       w_mem_entry;
  wb_entry_t       w_alu_entry;
  logic            w_nonempty;
  logic [CW:0]     w_free;
  logic            w_mem_push;
  logic            w_alu_push;

  assign w_nonempty = (q_count != '0);

  // A slot freed by this cycle's pop is usable by this cycle's pushes.
  assign w_free    = (CW+1)'(DEPTH) - {1'b0, q_count} + (CW+1)'(w_nonempty);
  assign mem_ready = (w_free >= (CW+1)'(1));
  assign alu_ready = mem_valid ? (w_free >= (CW+1)'(2)) : (w_free >= (CW+1)'(1));

  // Writes to r0 are accepted but dropped, since r0 is hardwired zero.
  assign w_mem_push = mem_valid && mem_ready && (mem_addr != '0);
  assign w_alu_push = alu_valid && alu_ready && (alu_addr != '0);

  assign w_mem_entry = '{addr: mem_addr, data: mem_data};
  assign w_alu_entry = '{addr: alu_addr, data: alu_data};

  // Load entry is pushed on port 0 so it lands ahead of a same-cycle ALU entry.
  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .i_push0       (w_mem_push),
    .i_push0_entry (w_mem_entry),
    .i_push1       (w_alu_push),
    .i_push1_entry (w_alu_entry),
    .i_pop         (w_nonempty),
    .o_entries     (w_entries),
    .o_valid       (w_valid),
    .o_count       (q_count)
  );

  // The head retires every cycle the queue is non-empty; no write-port stall.
  assign rf_write = w_nonempty;
  assign rf_wr    = w_entries[0].addr;
  assign rf_wd    = w_entries[0].data;

  // Scoreboard: mark every register targeted by a queued entry.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) begin
        pend_mask[w_entries[i].addr] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

`ifdef RF_WB_BYPASS_EN
  // Bypass lookup: scanning oldest to youngest lets the youngest match win.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (chk_rr1 != '0) && (w_entries[i].addr == chk_rr1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = w_entries[i].data;
      end
      if (w_valid[i] && (chk_rr2 != '0) && (w_entries[i].addr == chk_rr2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = w_entries[i].data;
      end
    end
  end
`else
  // Bypass disabled: lookup ports are kept for a stable interface only.
  logic w_unused_chk;
  assign w_unused_chk = ^{chk_rr1, chk_rr2};
  assign byp_hit1  = 1'b0;
  assign byp_data1 = '0;
  assign byp_hit2  = 1'b0;
  assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl against a queue-based model.
module tb_rf_writeback_ctrl;
  import rf_wb_pkg::*;

  localparam int DEPTH = 4;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready;
  logic [2:0]  alu_addr = '0, mem_addr = '0;
  logic [15:0] alu_data = '0, mem_data = '0;
  logic        rf_write;
  logic [2:0]  rf_wr;
  logic [15:0] rf_wd;
  logic [7:0]  pend_mask;
  logic [2:0]  q_count;
  logic [2:0]  chk_rr1 = '0, chk_rr2 = '0;
  logic        byp_hit1, byp_hit2;
  logic [15:0] byp_data1, byp_data2;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queued writes, oldest at index 0.
  wb_entry_t mq[$];

  always #5 clk = ~clk;

  rf_writeback_ctrl dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_write(rf_write), .rf_wr(rf_wr), .rf_wd(rf_wd),
    .pend_mask(pend_mask), .q_count(q_count),
    .chk_rr1(chk_rr1), .chk_rr2(chk_rr2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_hit2(byp_hit2), .byp_data2(byp_data2)
  );

  function automatic int m_free();
    return DEPTH - mq.size() + ((mq.size() > 0) ? 1 : 0);
  endfunction

  function automatic logic m_mem_ready();
    return m_free() >= 1;
  endfunction

  function automatic logic m_alu_ready();
    return mem_valid ? (m_free() >= 2) : (m_free() >= 1);
  endfunction

  function automatic logic [7:0] m_pend();
    logic [7:0] m = '0;
    foreach (mq[i]) m[mq[i].addr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // {hit, data} of the youngest queued write to rr.
  function automatic logic [16:0] m_byp(input logic [2:0] rr);
    logic [16:0] r = '0;
    if (BYP && rr != 3'd0) begin
      foreach (mq[i]) if (mq[i].addr == rr) r = {1'b1, mq[i].data};
    end
    return r;
  endfunction

  task automatic drive(input logic mv, input logic [2:0] ma, input logic [15:0] md,
                       input logic av, input logic [2:0] aa, input logic [15:0] ad);
    @(negedge clk);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    #1;
  endtask

  // Advance one clock edge and apply the specified accept/retire rules to the model.
  task automatic tick();
    logic m_ok, a_ok;
    wb_entry_t e;
    m_ok = mem_valid && m_mem_ready();
    a_ok = alu_valid && m_alu_ready();
    @(posedge clk);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      $display("[%0t] retire r%0d <= %04h", $time, e.addr, e.data);
    end
    if (m_ok) begin
      $display("[%0t] accept mem r%0d = %04h", $time, mem_addr, mem_data);
      if (mem_addr != 3'd0) mq.push_back('{addr: mem_addr, data: mem_data});
    end
    if (a_ok) begin
      $display("[%0t] accept alu r%0d = %04h", $time, alu_addr, alu_data);
      if (alu_addr != 3'd0) mq.push_back('{addr: alu_addr, data: alu_data});
    end
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL reset_rf_write got %b want 0", rf_write); end
    n_cmp++; if (rf_wr !== 3'd0) begin n_err++; $display("FAIL reset_rf_wr got %0d want 0", rf_wr); end
    n_cmp++; if (rf_wd !== 16'h0) begin n_err++; $display("FAIL reset_rf_wd got %h want 0", rf_wd); end
    n_cmp++; if (pend_mask !== 8'h0) begin n_err++; $display("FAIL reset_pend got %h want 00", pend_mask); end
    n_cmp++; if (q_count !== 3'd0) begin n_err++; $display("FAIL reset_q_count got %0d want 0", q_count); end
    n_cmp++; if ({byp_hit1, byp_hit2} !== 2'b00) begin n_err++; $display("FAIL reset_byp_hit got %b want 00", {byp_hit1, byp_hit2}); end
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic test_single_alu();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL single_alu_ready got %b want 1", alu_ready); end
    tick();
    idle();
    n_cmp++; if (rf_write !== 1'b1) begin n_err++; $display("FAIL single_rf_write got %b want 1", rf_write); end
    n_cmp++; if (rf_wr !== 3'd3) begin n_err++; $display("FAIL single_rf_wr got %0d want 3", rf_wr); end
    n_cmp++; if (rf_wd !== 16'h1234) begin n_err++; $display("FAIL single_rf_wd got %h want 1234", rf_wd); end
    n_cmp++; if (pend_mask !== 8'h08) begin n_err++; $display("FAIL single_pend got %h want 08", pend_mask); end
    tick();
    idle();
    n_cmp++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL single_idle_write got %b want 0", rf_write); end
    n_cmp++; if (q_count !== 3'd0) begin n_err++; $display("FAIL single_idle_count got %0d want 0", q_count); end
  endtask

  task automatic test_dual();
    drive(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd6, 16'h5555);
    n_cmp++; if ({mem_ready, alu_ready} !== 2'b11) begin n_err++; $display("FAIL dual_ready got %b want 11", {mem_ready, alu_ready}); end
    tick();
    idle();
    n_cmp++; if (q_count !== 3'd2) begin n_err++; $display("FAIL dual_count0 got %0d want 2", q_count); end
    n_cmp++; if ({rf_write, rf_wr, rf_wd} !== {1'b1, 3'd5, 16'hAAAA}) begin n_err++; $display("FAIL dual_first got %b/%0d/%h want 1/5/aaaa", rf_write, rf_wr, rf_wd); end
    n_cmp++; if (pend_mask !== 8'h60) begin n_err++; $display("FAIL dual_pend got %h want 60", pend_mask); end
    tick();
    idle();
    n_cmp++; if (q_count !== 3'd1) begin n_err++; $display("FAIL dual_count1 got %0d want 1", q_count); end
    n_cmp++; if ({rf_write, rf_wr, rf_wd} !== {1'b1, 3'd6, 16'h5555}) begin n_err++; $display("FAIL dual_second got %b/%0d/%h want 1/6/5555", rf_write, rf_wr, rf_wd); end
    tick();
    idle();
    n_cmp++; if (q_count !== 3'd0) begin n_err++; $display("FAIL dual_count2 got %0d want 0", q_count); end
  endtask

  task automatic test_backpressure();
    int drops = 0;
    logic [2:0]  a_addr = 3'd1;
    logic [15:0] a_data = 16'hA000;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 3'(c % 7 + 1), 16'hB000 + 16'(c), 1'b1, a_addr, a_data);
      n_cmp++; if (alu_ready !== m_alu_ready()) begin n_err++; $display("FAIL bp_alu_ready c%0d got %b want %b", c, alu_ready, m_alu_ready()); end
      n_cmp++; if (mem_ready !== m_mem_ready()) begin n_err++; $display("FAIL bp_mem_ready c%0d got %b want %b", c, mem_ready, m_mem_ready()); end
      n_cmp++; if (q_count !== 3'(mq.size())) begin n_err++; $display("FAIL bp_count c%0d got %0d want %0d", c, q_count, mq.size()); end
      if (mq.size() > 0) begin
        n_cmp++; if ({rf_write, rf_wr, rf_wd} !== {1'b1, mq[0].addr, mq[0].data}) begin n_err++; $display("FAIL bp_head c%0d got %b/%0d/%h want 1/%0d/%h", c, rf_write, rf_wr, rf_wd, mq[0].addr, mq[0].data); end
      end
      if (!m_alu_ready()) drops++;
      else begin a_addr = (a_addr == 3'd7) ? 3'd1 : a_addr + 3'd1; a_data = a_data + 16'h0011; end
      tick();
    end
    n_cmp++; if (drops == 0) begin n_err++; $display("FAIL bp_alu_drop got %0d drops want >0", drops); end
    for (int c = 0; c < DEPTH + 1; c++) begin
      idle();
      n_cmp++; if (q_count !== 3'(mq.size())) begin n_err++; $display("FAIL bp_drain_count got %0d want %0d", q_count, mq.size()); end
      if (mq.size() > 0) begin
        n_cmp++; if ({rf_wr, rf_wd} !== {mq[0].addr, mq[0].data}) begin n_err++; $display("FAIL bp_drain_head got %0d/%h want %0d/%h", rf_wr, rf_wd, mq[0].addr, mq[0].data); end
      end
      tick();
    end
  endtask

  task automatic test_r0();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'hFFFF);
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready got %b want 1", alu_ready); end
    tick();
    for (int c = 0; c < 2; c++) begin
      idle();
      n_cmp++; if ({rf_write, q_count} !== 4'b0000) begin n_err++; $display("FAIL r0_noqueue got %b/%0d want 0/0", rf_write, q_count); end
      tick();
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 3'd2, 16'h0011, 1'b1, 3'd2, 16'h0022);
    tick();
    chk_rr1 = 3'd2; chk_rr2 = 3'd0;
    idle();
`ifdef RF_WB_BYPASS_EN
    n_cmp++; if ({byp_hit1, byp_data1} !== {1'b1, 16'h0022}) begin n_err++; $display("FAIL byp1 got %b/%h want 1/0022", byp_hit1, byp_data1); end
`else
    n_cmp++; if ({byp_hit1, byp_data1} !== 17'h0) begin n_err++; $display("FAIL byp1_off got %b/%h want 0/0000", byp_hit1, byp_data1); end
`endif
    n_cmp++; if (byp_hit2 !== 1'b0) begin n_err++; $display("FAIL byp2_r0 got %b want 0", byp_hit2); end
    n_cmp++; if (pend_mask !== 8'h04) begin n_err++; $display("FAIL byp_pend got %h want 04", pend_mask); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd1, 16'h0101, 1'b1, 3'd4, 16'h0404);
    tick();
    drive(1'b1, 3'd7, 16'h0707, 1'b1, 3'd2, 16'h0202);
    tick();
    idle();
    n_cmp++; if (q_count !== 3'd3) begin n_err++; $display("FAIL mid_prefill got %0d want 3", q_count); end
    #1 reset = 1'b1;
    #1;
    mq.delete();
    n_cmp++; if ({rf_write, pend_mask, q_count} !== 12'h0) begin n_err++; $display("FAIL mid_reset got %b/%h/%0d want 0/00/0", rf_write, pend_mask, q_count); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      idle();
      n_cmp++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL mid_after_write got %b want 0", rf_write); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [16:0] b1, b2;
    for (int c = 0; c < 250; c++) begin
      chk_rr1 = 3'($urandom_range(0, 7));
      chk_rr2 = 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
      b1 = m_byp(chk_rr1);
      b2 = m_byp(chk_rr2);
      n_cmp++; if (rf_write !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_write c%0d got %b want %b", c, rf_write, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_cmp++; if ({rf_wr, rf_wd} !== {mq[0].addr, mq[0].data}) begin n_err++; $display("FAIL rnd_head c%0d got %0d/%h want %0d/%h", c, rf_wr, rf_wd, mq[0].addr, mq[0].data); end
      end
      n_cmp++; if (q_count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_count c%0d got %0d want %0d", c, q_count, mq.size()); end
      n_cmp++; if (pend_mask !== m_pend()) begin n_err++; $display("FAIL rnd_pend c%0d got %h want %h", c, pend_mask, m_pend()); end
      n_cmp++; if (mem_ready !== m_mem_ready()) begin n_err++; $display("FAIL rnd_mem_ready c%0d got %b want %b", c, mem_ready, m_mem_ready()); end
      n_cmp++; if (alu_ready !== m_alu_ready()) begin n_err++; $display("FAIL rnd_alu_ready c%0d got %b want %b", c, alu_ready, m_alu_ready()); end
      n_cmp++; if ({byp_hit1, byp_data1} !== b1) begin n_err++; $display("FAIL rnd_byp1 c%0d rr%0d got %b/%h want %b/%h", c, chk_rr1, byp_hit1, byp_data1, b1[16], b1[15:0]); end
      n_cmp++; if ({byp_hit2, byp_data2} !== b2) begin n_err++; $display("FAIL rnd_byp2 c%0d rr%0d got %b/%h want %b/%h", c, chk_rr2, byp_hit2, byp_data2, b2[16], b2[15:0]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_dual();
    test_backpressure();
    test_r0();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout reached at %0t want completion earlier", $time);
    $fatal(1);
  end

endmodule
